// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the reg_file write port between WB, MUL/DIV and host writers
module regfile_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            WB_VALID,
  input  logic [4:0]      WB_ADDR,
  input  logic [XLEN-1:0] WB_DATA,
  input  logic            MD_VALID,
  input  logic [4:0]      MD_ADDR,
  input  logic [XLEN-1:0] MD_DATA,
  output logic            MD_READY,
  input  logic            HOST_VALID,
  input  logic [4:0]      HOST_ADDR,
  input  logic [XLEN-1:0] HOST_DATA,
  output logic            HOST_READY,
  input  logic            MD_ISSUE,
  input  logic [4:0]      MD_ISSUE_RD,
  output logic            REG_WRITE,
  output logic [4:0]      REG_ADDR,
  output logic [XLEN-1:0] REG_DATA,
  output logic            STALL_WB,
  output logic [31:0]     BUSY_VEC
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  // 0 = MD preferred on a tie, 1 = HOST preferred
  logic             r_rr_ptr;
  logic [CNT_W-1:0] r_md_wait;
  logic [CNT_W-1:0] r_host_wait;
  logic             r_stall_wb;
  logic [31:0]      r_busy_vec;

  logic             w_grant_wb;
  logic             w_grant_md;
  logic             w_grant_host;
  logic             w_md_starved;
  logic             w_host_starved;
  logic [31:0]      w_busy_next;

  // Fixed priority for WB (never back-pressured), round-robin between MD and HOST; nothing granted in reset
  always_comb begin
    w_grant_wb   = !RESET && WB_VALID;
    w_grant_md   = !RESET && !WB_VALID && MD_VALID   && (!HOST_VALID || !r_rr_ptr);
    w_grant_host = !RESET && !WB_VALID && HOST_VALID && (!MD_VALID   ||  r_rr_ptr);
  end

  // Write-port mux; x0 writes are handshaken but never reach reg_file
  always_comb begin
    REG_ADDR = 5'd0;
    REG_DATA = '0;
    if (w_grant_wb) begin
      REG_ADDR = WB_ADDR;
      REG_DATA = WB_DATA;
    end else if (w_grant_md) begin
      REG_ADDR = MD_ADDR;
      REG_DATA = MD_DATA;
    end else if (w_grant_host) begin
      REG_ADDR = HOST_ADDR;
      REG_DATA = HOST_DATA;
    end
    REG_WRITE  = (w_grant_wb || w_grant_md || w_grant_host) && (REG_ADDR != 5'd0);
    MD_READY   = w_grant_md;
    HOST_READY = w_grant_host;
  end

  // A saturated requester that is still waiting keeps the WB stall request alive
  always_comb begin
    w_md_starved   = MD_VALID   && !w_grant_md   && (r_md_wait   == LIMIT);
    w_host_starved = HOST_VALID && !w_grant_host && (r_host_wait == LIMIT);
  end

  // Scoreboard update: grant clears, a same-cycle issue re-sets, x0 never busy
  always_comb begin
    w_busy_next = r_busy_vec;
    if (w_grant_md) begin
      w_busy_next[MD_ADDR] = 1'b0;
    end
    if (MD_ISSUE && (MD_ISSUE_RD != 5'd0)) begin
      w_busy_next[MD_ISSUE_RD] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  // Round-robin pointer, wait counters, stall flag and busy scoreboard
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rr_ptr    <= 1'b0;
      r_md_wait   <= '0;
      r_host_wait <= '0;
      r_stall_wb  <= 1'b0;
      r_busy_vec  <= '0;
    end else begin
      if (w_grant_md) begin
        r_rr_ptr <= 1'b1;
      end else if (w_grant_host) begin
        r_rr_ptr <= 1'b0;
      end

      if (!MD_VALID || w_grant_md) begin
        r_md_wait <= '0;
      end else if (r_md_wait != LIMIT) begin
        r_md_wait <= r_md_wait + 1'b1;
      end

      if (!HOST_VALID || w_grant_host) begin
        r_host_wait <= '0;
      end else if (r_host_wait != LIMIT) begin
        r_host_wait <= r_host_wait + 1'b1;
      end

      r_stall_wb <= w_md_starved || w_host_starved;
      r_busy_vec <= w_busy_next;
    end
  end

  assign STALL_WB = r_stall_wb;
  assign BUSY_VEC = r_busy_vec;

endmodule
